// File: rtl/sevenseg_scan_driver_if.sv
// Signal bundle between a user project and the 4-digit 7-segment scan driver.
// master = user logic supplying the value, slave = the scan driver.
interface sevenseg_scan_driver_if;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_sync;

  modport master (
    output value,
    output dp_in,
    output load,
    output blank,
    input  seg,
    input  dp,
    input  an,
    input  frame_sync
  );

  modport slave (
    input  value,
    input  dp_in,
    input  load,
    input  blank,
    output seg,
    output dp,
    output an,
    output frame_sync
  );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// Basys3 4-digit multiplexed 7-segment driver with frame-aligned value commit.
// Optional leading-zero blanking: define SEVENSEG_LEADING_ZERO_BLANK_EN.
module sevenseg_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned PRESCALE_W  = $clog2(REFRESH_DIV)
) (
  input  logic                  clock,
  input  logic                  reset,
  sevenseg_scan_driver_if.slave bus
);

  typedef enum logic [1:0] {
    SLOT0 = 2'd0,
    SLOT1 = 2'd1,
    SLOT2 = 2'd2,
    SLOT3 = 2'd3
  } slot_t;

  localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(REFRESH_DIV - 1);

  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [PRESCALE_W-1:0] prescaler;
  logic [PRESCALE_W-1:0] prescaler_next;
  slot_t                 slot;
  slot_t                 slot_next;

  logic                  tick;
  logic                  frame_end;
  logic                  commit;

  logic [15:0]           pend_val;
  logic [15:0]           pend_val_next;
  logic [3:0]            pend_dp;
  logic [3:0]            pend_dp_next;
  logic                  pend_flag;
  logic                  pend_flag_next;

  logic [15:0]           disp_val;
  logic [15:0]           disp_val_next;
  logic [3:0]            disp_dp;
  logic [3:0]            disp_dp_next;

  logic [3:0]            nibble_next;
  logic                  dp_bit_next;
  logic [3:0]            slot_onehot;
  logic [3:0]            lz_off;

  logic [3:0]            an_next;
  logic [6:0]            seg_next;
  logic                  dp_next;

  logic [3:0]            an_q;
  logic [6:0]            seg_q;
  logic                  dp_q;
  logic                  frame_sync_q;

  // Scan timing: prescaler and digit slot
  always_comb begin
    prescaler_next = prescaler;
    slot_next      = slot;
    tick           = (prescaler == PRESCALE_LAST);
    frame_end      = tick && (slot == SLOT3);

    if (tick) begin
      prescaler_next = '0;
      case (slot)
        SLOT0:   slot_next = SLOT1;
        SLOT1:   slot_next = SLOT2;
        SLOT2:   slot_next = SLOT3;
        default: slot_next = SLOT0;
      endcase
    end else begin
      prescaler_next = prescaler + 1'b1;
    end
  end

  // A load on the frame_end cycle bypasses the pending buffer and commits directly
  always_comb begin
    pend_val_next  = pend_val;
    pend_dp_next   = pend_dp;
    pend_flag_next = pend_flag;
    disp_val_next  = disp_val;
    disp_dp_next   = disp_dp;
    commit         = frame_end && (pend_flag || bus.load);

    if (bus.load) begin
      pend_val_next  = bus.value;
      pend_dp_next   = bus.dp_in;
      pend_flag_next = 1'b1;
    end

    if (commit) begin
      pend_flag_next = 1'b0;
      if (bus.load) begin
        disp_val_next = bus.value;
        disp_dp_next  = bus.dp_in;
      end else begin
        disp_val_next = pend_val;
        disp_dp_next  = pend_dp;
      end
    end
  end

  // Digit data for the slot that will be shown after this edge
  always_comb begin
    nibble_next = disp_val_next[3:0];
    dp_bit_next = disp_dp_next[0];
    slot_onehot = 4'b0001;
    case (slot_next)
      SLOT0: begin
        nibble_next = disp_val_next[3:0];
        dp_bit_next = disp_dp_next[0];
        slot_onehot = 4'b0001;
      end
      SLOT1: begin
        nibble_next = disp_val_next[7:4];
        dp_bit_next = disp_dp_next[1];
        slot_onehot = 4'b0010;
      end
      SLOT2: begin
        nibble_next = disp_val_next[11:8];
        dp_bit_next = disp_dp_next[2];
        slot_onehot = 4'b0100;
      end
      default: begin
        nibble_next = disp_val_next[15:12];
        dp_bit_next = disp_dp_next[3];
        slot_onehot = 4'b1000;
      end
    endcase
  end

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
  logic zero_run3;
  logic zero_run2;
  logic zero_run1;

  // Digit k goes dark when it and every digit left of it is zero and its dp is off
  always_comb begin
    zero_run3 = (disp_val_next[15:12] == 4'h0);
    zero_run2 = zero_run3 && (disp_val_next[11:8] == 4'h0);
    zero_run1 = zero_run2 && (disp_val_next[7:4] == 4'h0);
    lz_off    = '0;
    lz_off[3] = zero_run3 && !disp_dp_next[3];
    lz_off[2] = zero_run2 && !disp_dp_next[2];
    lz_off[1] = zero_run1 && !disp_dp_next[1];
  end
`else
  assign lz_off = '0;
`endif

  always_comb begin
    seg_next = hex_to_seg(nibble_next);
    dp_next  = ~dp_bit_next;
    if (bus.blank) begin
      an_next = '1;
    end else begin
      an_next = ~slot_onehot | lz_off;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prescaler    <= '0;
      slot         <= SLOT0;
      pend_val     <= '0;
      pend_dp      <= '0;
      pend_flag    <= 1'b0;
      disp_val     <= '0;
      disp_dp      <= '0;
      an_q         <= '1;
      seg_q        <= '1;
      dp_q         <= 1'b1;
      frame_sync_q <= 1'b0;
    end else begin
      prescaler    <= prescaler_next;
      slot         <= slot_next;
      pend_val     <= pend_val_next;
      pend_dp      <= pend_dp_next;
      pend_flag    <= pend_flag_next;
      disp_val     <= disp_val_next;
      disp_dp      <= disp_dp_next;
      an_q         <= an_next;
      seg_q        <= seg_next;
      dp_q         <= dp_next;
      frame_sync_q <= commit;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_sync = frame_sync_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver with REFRESH_DIV = 4 (16-cycle frame).
// Edge index n counts clock edges since reset release; frame_end edges are n % 16 == 15.
module tb_sevenseg_scan_driver;

  logic clock = 1'b0;
  logic reset = 1'b1;

  sevenseg_scan_driver_if bus_if ();

  sevenseg_scan_driver #(.REFRESH_DIV(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;
  int n           = -1;
  int sync_seen   = 0;

  logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    n++;
    if (bus_if.frame_sync) sync_seen++;
  endtask

  task automatic goto(input int k);
    while (n < k) step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_an"},  {12'h0, bus_if.an},   16'h000F);
    chk({tag, "_seg"}, {9'h0, bus_if.seg},   16'h007F);
    chk({tag, "_dp"},  {15'h0, bus_if.dp},   16'h0001);
    chk({tag, "_fs"},  {15'h0, bus_if.frame_sync}, 16'h0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;

    bus_if.value = '0;
    bus_if.dp_in = '0;
    bus_if.load  = 1'b0;
    bus_if.blank = 1'b0;

    // Reset held for three edges
    for (int i = 0; i < 3; i++) begin
      step();
      chk_reset_outputs("reset_hold");
    end
    reset = 1'b0;
    n = -1;

    // First slot after release: digit 0 showing "0"
    goto(0);
    chk("rel_an",  {12'h0, bus_if.an},  16'h000E);
    chk("rel_seg", {9'h0, bus_if.seg},  16'h0040);
    chk("rel_dp",  {15'h0, bus_if.dp},  16'h0001);
    goto(2);
    chk("slot0_hold_an", {12'h0, bus_if.an}, 16'h000E);
    goto(3);
    chk("first_tick_an",  {12'h0, bus_if.an}, 16'h000D);
    chk("first_tick_seg", {9'h0, bus_if.seg}, 16'h0040);

    // Mid-frame load of 0x1234, committed at frame_end (edge 15)
    goto(4);
    bus_if.value = 16'h1234;
    bus_if.dp_in = 4'b0000;
    bus_if.load  = 1'b1;
    goto(5);
    bus_if.load  = 1'b0;
    sync_seen    = 0;
    chk("pend_no_fs",  {15'h0, bus_if.frame_sync}, 16'h0000);
    chk("pend_old_seg", {9'h0, bus_if.seg}, 16'h0040);
    goto(14);
    chk("pend_d3_an",  {12'h0, bus_if.an},  16'h0007);
    chk("pend_d3_seg", {9'h0, bus_if.seg},  16'h0040);
    goto(15);
    chk("commit_fs",     {15'h0, bus_if.frame_sync}, 16'h0001);
    chk("commit_d0_an",  {12'h0, bus_if.an},  16'h000E);
    chk("commit_d0_seg", {9'h0, bus_if.seg},  16'h0019);
    goto(16);
    chk("commit_fs_drop", {15'h0, bus_if.frame_sync}, 16'h0000);
    goto(19);
    chk("d1_an",  {12'h0, bus_if.an}, 16'h000D);
    chk("d1_seg", {9'h0, bus_if.seg}, 16'h0030);
    goto(23);
    chk("d2_an",  {12'h0, bus_if.an}, 16'h000B);
    chk("d2_seg", {9'h0, bus_if.seg}, 16'h0024);
    goto(27);
    chk("d3_an",  {12'h0, bus_if.an}, 16'h0007);
    chk("d3_seg", {9'h0, bus_if.seg}, 16'h0079);
    goto(30);
    chk("single_fs_1234", sync_seen[15:0], 16'd1);

    // Two loads in one frame: last one wins
    goto(32);
    sync_seen    = 0;
    bus_if.value = 16'hAAAA;
    bus_if.load  = 1'b1;
    goto(33);
    bus_if.value = 16'h5B0F;
    goto(34);
    bus_if.load  = 1'b0;
    goto(46);
    chk("dbl_old_d3_seg", {9'h0, bus_if.seg}, 16'h0079);
    goto(47);
    chk("dbl_fs",     {15'h0, bus_if.frame_sync}, 16'h0001);
    chk("dbl_d0_seg", {9'h0, bus_if.seg}, 16'h000E);
    goto(51);
    chk("dbl_d1_seg", {9'h0, bus_if.seg}, 16'h0040);
    goto(55);
    chk("dbl_d2_seg", {9'h0, bus_if.seg}, 16'h0003);
    goto(59);
    chk("dbl_d3_seg", {9'h0, bus_if.seg}, 16'h0012);
    chk("dbl_single_fs", sync_seen[15:0], 16'd1);

    // Load exactly on the frame_end cycle (edge 63)
    goto(62);
    bus_if.value = 16'hCDEF;
    bus_if.load  = 1'b1;
    goto(63);
    bus_if.load  = 1'b0;
    chk("byp_fs",     {15'h0, bus_if.frame_sync}, 16'h0001);
    chk("byp_d0_an",  {12'h0, bus_if.an}, 16'h000E);
    chk("byp_d0_seg", {9'h0, bus_if.seg}, 16'h000E);
    goto(67);
    chk("byp_d1_seg", {9'h0, bus_if.seg}, 16'h0006);
    goto(79);
    chk("byp_no_pend_fs", {15'h0, bus_if.frame_sync}, 16'h0000);
    chk("byp_keep_seg",   {9'h0, bus_if.seg}, 16'h000E);

    // Commit 0x8421 with dp on digit 2, then blank for 10 cycles
    goto(80);
    bus_if.value = 16'h8421;
    bus_if.dp_in = 4'b0100;
    bus_if.load  = 1'b1;
    goto(81);
    bus_if.load  = 1'b0;
    bus_if.value = 16'h0000;
    bus_if.dp_in = 4'b0000;
    goto(95);
    chk("dp_fs",     {15'h0, bus_if.frame_sync}, 16'h0001);
    chk("dp_d0_seg", {9'h0, bus_if.seg}, 16'h0079);
    chk("dp_d0_dp",  {15'h0, bus_if.dp}, 16'h0001);
    goto(97);
    bus_if.blank = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("blank_an", {12'h0, bus_if.an}, 16'h000F);
    end
    bus_if.blank = 1'b0;
    goto(108);
    chk("unblank_an",  {12'h0, bus_if.an}, 16'h0007);
    chk("unblank_seg", {9'h0, bus_if.seg}, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      step();
      d = ((n + 1) / 4) % 4;
      chk("scan_an", {12'h0, bus_if.an}, {12'h0, an_tab[d]});
      chk("scan_dp", {15'h0, bus_if.dp}, (d == 2) ? 16'h0000 : 16'h0001);
    end

    // Leading zeros: 0x0042
    goto(124);
    bus_if.value = 16'h0042;
    bus_if.dp_in = 4'b0000;
    bus_if.load  = 1'b1;
    goto(125);
    bus_if.load  = 1'b0;
    goto(127);
    chk("lz_fs", {15'h0, bus_if.frame_sync}, 16'h0001);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) step();
      d = ((n + 1) / 4) % 4;
      case (d)
        0:       exp_seg = 7'b0100100;
        1:       exp_seg = 7'b0011001;
        default: exp_seg = 7'b1000000;
      endcase
      exp_an = an_tab[d];
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
      if (d >= 2) exp_an = 4'b1111;
`endif
      chk("lz_an",  {12'h0, bus_if.an}, {12'h0, exp_an});
      chk("lz_seg", {9'h0, bus_if.seg}, {9'h0, exp_seg});
    end

    // Reset while a load is pending clears everything
    goto(144);
    bus_if.value = 16'hFFFF;
    bus_if.dp_in = 4'b1111;
    bus_if.load  = 1'b1;
    goto(145);
    bus_if.load  = 1'b0;
    reset        = 1'b1;
    goto(146);
    chk_reset_outputs("mid_reset");
    reset = 1'b0;
    n = -1;
    goto(0);
    chk("post_rst_an",  {12'h0, bus_if.an},  16'h000E);
    chk("post_rst_seg", {9'h0, bus_if.seg},  16'h0040);
    chk("post_rst_dp",  {15'h0, bus_if.dp},  16'h0001);
    goto(15);
    chk("post_rst_no_fs",  {15'h0, bus_if.frame_sync}, 16'h0000);
    chk("post_rst_d0_seg", {9'h0, bus_if.seg}, 16'h0040);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
